// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared state type, constants and scan-order mapping (TT_GRAY_ORDER_EN selects Gray order)
package truth_table_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int NUM_COMB = 8;
  localparam logic [2:0] LAST_STEP = 3'd7;
  function automatic logic [2:0] step_to_code(input logic [2:0] s);
`ifdef TT_GRAY_ORDER_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction
endpackage

// File: rtl/truth_table_scanner_dwell.sv
// tt_dwell_counter: counts 0..DWELL-1 while enabled and flags the final clock of each hold
module tt_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);
  localparam int W = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [W-1:0] count;
  assign last = count == W'(DWELL - 1);
  // wrap on the last clock so the next combination starts its hold from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= last ? '0 : count + W'(1);
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps {a,b,c} through all 8 codes, holds each DWELL clocks and captures y into an 8-bit table (TT_GRAY_ORDER_EN: Gray order)
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                y,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                busy,
  output logic                done,
  output logic [NUM_COMB-1:0] truth_table
);
  state_t state, state_n;
  logic [2:0] step, step_n, abc, abc_n;
  logic [NUM_COMB-1:0] tt_n;
  logic done_n, clear, last;
  tt_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (state == SCAN),
    .last   (last)
  );
  assign {a, b, c} = abc;
  assign busy = state == SCAN;
  // next-state: accept start in IDLE, capture y at the end of each hold, finish after the eighth code
  always_comb begin
    state_n = state;
    step_n  = step;
    abc_n   = abc;
    done_n  = done;
    tt_n    = truth_table;
    clear   = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = SCAN;
        step_n  = 3'd0;
        abc_n   = step_to_code(3'd0);
        done_n  = 1'b0;
        tt_n    = '0;
        clear   = 1'b1;
      end
    end else if (last) begin
      tt_n[abc] = y;
      if (step != LAST_STEP) begin
        step_n = step + 3'd1;
        abc_n  = step_to_code(step + 3'd1);
      end else begin
        state_n = IDLE;
        step_n  = 3'd0;
        abc_n   = 3'd0;
        done_n  = 1'b1;
      end
    end
  end
  // state register; a,b,c come straight from flops so y settles well before capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      step        <= 3'd0;
      abc         <= 3'd0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      abc         <= abc_n;
      done        <= done_n;
      truth_table <= tt_n;
    end
endmodule
